jk_bank_driver: RTL and testbench
=================================

Name: jk_bank_driver

Overview:
- Drives a bank of WIDTH JK flip-flops (jkff instances sharing clk) to a requested target value.
- Accepts a target over a valid/ready handshake and converts current bank state plus target into J/K inputs using the JK excitation table.
- Reads the bank's q outputs back, checks the result, and retries up to a bounded count.
- Sits between a controller issuing register-load requests and a JK flop bank.

Parameters:
- WIDTH, 4, number of JK flops in the bank
- MAX_RETRY, 2, re-drive attempts after a failed check before error (0 = no retry)

Ports:
- clk  input  1  rising-edge clock, shared with the flop bank
- rst  input  1  synchronous active-high reset
- tgt_valid  input  1  target request valid
- tgt_ready  output  1  driver can accept a target
- tgt_data  input  WIDTH  requested bank value
- q_in  input  WIDTH  q outputs read back from the flop bank
- j_out  output  WIDTH  J inputs to the bank
- k_out  output  WIDTH  K inputs to the bank
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse: bank matches target
- err  output  1  one-cycle pulse: retries exhausted, bank mismatches

Behaviour:
- Reset (synchronous, rst high at a clk edge): state=IDLE, target_r=0, retry_cnt=0, done=0, err=0. j_out=k_out=0, so the bank holds. tgt_ready is 0 while rst is high. Reset mid-operation aborts immediately and produces no done/err pulse.
- tgt_ready = (state==IDLE) && !rst. Transfer occurs on the edge where tgt_valid && tgt_ready. tgt_data is latched into target_r, retry_cnt is cleared, and the state moves to DRIVE.
- States:
  - IDLE: j_out=k_out=0.
  - DRIVE (one cycle): j_out/k_out are combinational from q_in and target_r, per bit:
    - q=0, t=0: J=0, K=0
    - q=0, t=1: J=1, K=0
    - q=1, t=0: J=0, K=1
    - q=1, t=1: J=0, K=0
    - The bank samples these at the edge leaving DRIVE. Next state is CHECK.
  - CHECK (one cycle): j_out=k_out=0. At the edge leaving CHECK, q_in is compared to target_r:
    - match: done=1 for the next cycle; state goes to IDLE.
    - mismatch with retry_cnt<MAX_RETRY: retry_cnt increments; state goes back to DRIVE.
    - mismatch with retry_cnt==MAX_RETRY: err=1 for the next cycle; state goes to IDLE.
- Latency: from the accept edge, done is high in the 2nd cycle after acceptance (accept edge, then DRIVE, then CHECK). Each retry adds 2 cycles. Worst-case error latency is 2*(MAX_RETRY+1) cycles.
- done/err are registered, mutually exclusive, and never high during rst.
- busy = (state!=IDLE).
- In the cycle where done or err is high, the state is IDLE and tgt_ready is high, so back-to-back requests are accepted.
- J=K=1 is never driven in the default build. j_out and k_out are never both high on the same bit.
- A target equal to the current bank value still runs DRIVE/CHECK (all-zero J/K) and returns done.
- tgt_data/tgt_valid changes while busy are ignored (tgt_ready=0).

Optional Feature:
- Macro: JK_TOGGLE_EN
- Defined: in DRIVE, every bit where q_in != target_r is driven J=1, K=1 (toggle). Bits that already match are driven J=0, K=0. The CHECK and retry logic are unchanged.
- Not defined: the set/reset excitation above is used; J=K=1 never occurs.

Test Plan:
- Reset, then bank=4'b0000 and tgt_data=4'b1010 accepted -> DRIVE cycle shows j_out=4'b1010, k_out=4'b0000; done pulses 2 cycles after accept; q_in=4'b1010.
- Bank=4'b1111, target 4'b0101 -> j_out=4'b0000, k_out=4'b1010; done after 2 cycles. With JK_TOGGLE_EN: j_out=k_out=4'b1010.
- Bench forces q_in stuck at 4'b0000, target 4'b0001, MAX_RETRY=2 -> 3 DRIVE cycles; err pulses at cycle 6 after accept; done never asserts.
- Stuck bit releases after first failed check, target 4'b0001 -> one retry; done at cycle 4 after accept; err stays 0.
- rst asserted during CHECK -> next cycle: state IDLE, j_out=k_out=0, no done/err; tgt_ready=1 once rst drops.
- Two targets back-to-back (4'b0011, then 4'b1100 held valid) -> second accepted in the done cycle of the first; both complete with done; no idle gap beyond the done cycle.

Source files
------------

// File: rtl/jk_bank_driver_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jk_bank_driver_if : target handshake and JK flop-bank signals
// Rev 1.0
// ----------------------------------------------------------------------------
interface jk_bank_driver_if #(
  parameter int WIDTH = 4
) ();
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output tgt_valid, tgt_data, q_in,
    input  tgt_ready, j_out, k_out, busy, done, err
  );

  modport slave (
    input  tgt_valid, tgt_data, q_in,
    output tgt_ready, j_out, k_out, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jk_bank_driver : drives a JK flop bank to a requested value, checks, retries
// Optional macro JK_TOGGLE_EN: toggle (J=K=1) mismatching bits instead of set/reset
// Rev 1.0
// ----------------------------------------------------------------------------
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  jk_bank_driver_if.slave   bus
);

  localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] c_max_retry = CNT_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   j_drive;
  logic [WIDTH-1:0]   k_drive;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.tgt_valid) begin
          target_d = bus.tgt_data;
          retry_d  = '0;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (bus.q_in == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_q < c_max_retry) begin
          retry_d = retry_q + CNT_W'(1);
          state_d = ST_DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset dominates, so a mid-operation abort never leaves a done/err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      retry_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Excitation is combinational from the live bank value during DRIVE only.
  always_comb begin
    j_drive = '0;
    k_drive = '0;
    if (state_q == ST_DRIVE) begin
`ifdef JK_TOGGLE_EN
      j_drive = bus.q_in ^ target_q;
      k_drive = bus.q_in ^ target_q;
`else
      j_drive = ~bus.q_in & target_q;
      k_drive = bus.q_in & ~target_q;
`endif
    end
  end

  assign bus.tgt_ready = (state_q == ST_IDLE) && !rst;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.j_out     = j_drive;
  assign bus.k_out     = k_drive;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_jk_bank_driver : directed vector bench with a behavioural JK bank
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_jk_bank_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  jk_bank_driver_if #(.WIDTH(4)) bus ();

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural flop bank; force_en overrides it (preload or stuck bits).
  logic [3:0] bank_q    = 4'b0000;
  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'b0000;

  always @(posedge clk) begin
    if (force_en) bank_q <= force_val;
    else          bank_q <= (bus.j_out & ~bank_q) | (~bus.k_out & bank_q);
  end
  assign bus.q_in = bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] v, input logic hold);
    force_en  = 1'b1;
    force_val = v;
    step();
    force_en  = hold;
  endtask

  task automatic accept(input logic [3:0] t);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = t;
    step();
    bus.tgt_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] bank;
    logic [3:0] tgt;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int drives;
    logic seen_done;
    logic err_early;

`ifdef JK_TOGGLE_EN
    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010};
    vecs[1] = '{4'b1111, 4'b0101, 4'b1010, 4'b1010};
    vecs[2] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000};
    vecs[3] = '{4'b0110, 4'b1001, 4'b1111, 4'b1111};
    vecs[4] = '{4'b0011, 4'b0101, 4'b0110, 4'b0110};
    vecs[5] = '{4'b1001, 4'b1111, 4'b0110, 4'b0110};
`else
    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000};
    vecs[1] = '{4'b1111, 4'b0101, 4'b0000, 4'b1010};
    vecs[2] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000};
    vecs[3] = '{4'b0110, 4'b1001, 4'b1001, 4'b0110};
    vecs[4] = '{4'b0011, 4'b0101, 4'b0100, 4'b0010};
    vecs[5] = '{4'b1001, 4'b1111, 4'b0110, 4'b0000};
`endif

    bus.tgt_valid = 1'b0;
    bus.tgt_data  = 4'b0000;

    // Reset state
    step();
    step();
    chk("rst_ready", bus.tgt_ready, 0);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_done",  bus.done,      0);
    chk("rst_err",   bus.err,       0);
    chk("rst_jk",    {bus.j_out, bus.k_out}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.tgt_ready, 1);

    // Single-pass vectors
    for (int i = 0; i < 6; i++) begin
      preload(vecs[i].bank, 1'b0);
      accept(vecs[i].tgt);
      chk($sformatf("v%0d_busy", i), bus.busy, 1);
      chk($sformatf("v%0d_j", i), bus.j_out, vecs[i].exp_j);
      chk($sformatf("v%0d_k", i), bus.k_out, vecs[i].exp_k);
      step();
      chk($sformatf("v%0d_check_jk", i), {bus.j_out, bus.k_out}, 0);
      chk($sformatf("v%0d_done_early", i), bus.done, 0);
      step();
      chk($sformatf("v%0d_done", i), bus.done, 1);
      chk($sformatf("v%0d_err", i), bus.err, 0);
      chk($sformatf("v%0d_ready", i), bus.tgt_ready, 1);
      chk($sformatf("v%0d_bank", i), bus.q_in, vecs[i].tgt);
      step();
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
    end

    // Stuck bank: retries exhausted, err at cycle 6
    preload(4'b0000, 1'b1);
    accept(4'b0001);
    drives    = (bus.j_out != 4'b0000) ? 1 : 0;
    seen_done = 1'b0;
    err_early = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (bus.j_out != 4'b0000) drives++;
      if (bus.done) seen_done = 1'b1;
      if (c < 6 && bus.err) err_early = 1'b1;
    end
    chk("stuck_err",       bus.err,   1);
    chk("stuck_err_early", err_early, 0);
    chk("stuck_drives",    drives,    3);
    chk("stuck_no_done",   seen_done, 0);
    chk("stuck_idle",      bus.busy,  0);
    step();
    chk("stuck_err_pulse", bus.err,   0);
    force_en = 1'b0;

    // Stuck bit releases after the first failed check
    preload(4'b0000, 1'b1);
    accept(4'b0001);
    step();
    force_en = 1'b0;
    step();
    chk("retry_mid_done", bus.done, 0);
    chk("retry_mid_err",  bus.err,  0);
    chk("retry_mid_busy", bus.busy, 1);
    step();
    step();
    chk("retry_done", bus.done, 1);
    chk("retry_err",  bus.err,  0);

    // Reset during CHECK aborts with no pulse
    preload(4'b0000, 1'b0);
    accept(4'b0110);
    step();
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", bus.tgt_ready, 0);
    step();
    chk("abort_busy", bus.busy, 0);
    chk("abort_jk",   {bus.j_out, bus.k_out}, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_err",  bus.err,  0);
    rst = 1'b0;
    #1;
    chk("abort_ready", bus.tgt_ready, 1);
    step();
    chk("abort_no_late_done", bus.done, 0);

    // Back-to-back targets
    preload(4'b0000, 1'b0);
    accept(4'b0011);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b1100;
    step();
    chk("b2b_ignored_busy", bus.j_out, 4'b0000);
    step();
    chk("b2b_done1",  bus.done,      1);
    chk("b2b_ready1", bus.tgt_ready, 1);
    step();
    bus.tgt_valid = 1'b0;
    chk("b2b_busy2", bus.busy, 1);
`ifdef JK_TOGGLE_EN
    chk("b2b_j2", bus.j_out, 4'b1111);
    chk("b2b_k2", bus.k_out, 4'b1111);
`else
    chk("b2b_j2", bus.j_out, 4'b1100);
    chk("b2b_k2", bus.k_out, 4'b0011);
`endif
    step();
    step();
    chk("b2b_done2", bus.done, 1);
    chk("b2b_bank2", bus.q_in, 4'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
